// File: rtl/colour_bar_pattern_gen.sv
// Colour-bar test-pattern generator for VGA_controller.
// Draws NUM_BARS bars inside a horizontal band, with optional colour
// rotation or band blinking stepped every FRAMES_PER_STEP frames.
// Column position within the bar pattern is tracked with a phase counter
// and a bar-index counter instead of a divider.
module colour_bar_pattern_gen #(
  parameter int NUM_BARS        = 7,
  parameter int BAR_WIDTH       = 75,
  parameter int GAP             = 15,
  parameter int X_START         = 0,
  parameter int Y_START         = 220,
  parameter int Y_HEIGHT        = 40,
  parameter int FRAMES_PER_STEP = 60
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] mode,
  input  logic [9:0] pixel_X_pos,
  input  logic [9:0] pixel_Y_pos,
  output logic [7:0] VGA_red,
  output logic [7:0] VGA_green,
  output logic [7:0] VGA_blue,
  output logic       frame_tick,
  output logic [2:0] colour_offset
);

  localparam int PERIOD = GAP + BAR_WIDTH;
  localparam int PW     = $clog2(PERIOD + 1);
  localparam int FCW    = $clog2(FRAMES_PER_STEP + 1);

  localparam logic [PW-1:0]  PHASE_LAST = PW'(PERIOD - 1);
  localparam logic [PW-1:0]  GAP_L      = PW'(GAP);
  localparam logic [3:0]     NB_L       = 4'(NUM_BARS);
  localparam logic [2:0]     OFF_LAST   = 3'(NUM_BARS - 1);
  localparam logic [FCW-1:0] FCNT_LAST  = FCW'(FRAMES_PER_STEP - 1);
  localparam logic [9:0]     X_START_L  = 10'(X_START);
  localparam logic [10:0]    Y_START_L  = 11'(Y_START);
  localparam logic [10:0]    Y_END_L    = 11'(Y_START + Y_HEIGHT);

  localparam logic [1:0] MODE_ROTATE = 2'b01;
  localparam logic [1:0] MODE_BLINK  = 2'b10;

  // Palette lookup; index is already reduced modulo NUM_BARS.
  function automatic logic [23:0] palette(input logic [3:0] c);
    case (c)
      4'd0:    return 24'hFF0000;
      4'd1:    return 24'hFFFF00;
      4'd2:    return 24'hFFFFFF;
      4'd3:    return 24'h00FFFF;
      4'd4:    return 24'h00FF00;
      4'd5:    return 24'h0000FF;
      4'd6:    return 24'hFF00FF;
      default: return 24'h808080;
    endcase
  endfunction

  // (bar + offset) mod NUM_BARS; both operands are below NUM_BARS when lit.
  function automatic logic [3:0] wrap_bar(input logic [3:0] bar, input logic [2:0] off);
    logic [3:0] s;
    s = bar + {1'b0, off};
    return (s >= NB_L) ? (s - NB_L) : s;
  endfunction

  // Column tracking state: values describe the column following the last
  // enabled one, assuming the controller scans columns in order.
  logic [PW-1:0]  phase_q;
  logic [3:0]     bar_q;
  logic           line_ok_q;

  // Frame / mode control state.
  logic           seen_q;
  logic [1:0]     mode_q;
  logic [FCW-1:0] fcnt_q;
  logic           blink_q;
  logic [2:0]     offset_q;

  // Output stage.
  logic [23:0]    rgb_p1;
  logic           tick_p1;

  // ---- stage 0: geometry and frame decode on the current coordinates ----
  logic           line_start;
  logic [PW-1:0]  phase_cur, phase_nxt;
  logic [3:0]     bar_cur, bar_nxt;
  logic           in_x, in_gap_ok, y_ge, y_lt, lit;
  logic           at_origin, frame_start, mode_chg;

  assign line_start = (pixel_X_pos == X_START_L);
  assign phase_cur  = line_start ? '0 : phase_q;
  assign bar_cur    = line_start ? '0 : bar_q;

  if (X_START == 0) begin : g_x0
    assign in_x = 1'b1;
  end else begin : g_xn
    assign in_x = (pixel_X_pos >= X_START_L);
  end

  if (GAP == 0) begin : g_gap0
    assign in_gap_ok = 1'b1;
  end else begin : g_gapn
    assign in_gap_ok = (phase_cur >= GAP_L);
  end

  if (Y_START == 0) begin : g_y0
    assign y_ge = 1'b1;
  end else begin : g_yn
    assign y_ge = ({1'b0, pixel_Y_pos} >= Y_START_L);
  end

  assign y_lt = ({1'b0, pixel_Y_pos} < Y_END_L);

  // A pixel is only trusted once a line start has been seen since reset.
  assign lit = in_x && (line_ok_q || line_start) && (bar_cur < NB_L) &&
               in_gap_ok && y_ge && y_lt && !blink_q;

  assign at_origin   = (pixel_X_pos == 10'd0) && (pixel_Y_pos == 10'd0);
  assign frame_start = enable && at_origin && !seen_q;
  assign mode_chg    = (mode != mode_q);

  // Next column position; bar index saturates at NUM_BARS past the last bar.
  always_comb begin
    phase_nxt = phase_cur + PW'(1);
    bar_nxt   = bar_cur;
    if (phase_cur == PHASE_LAST) begin
      phase_nxt = '0;
      if (bar_cur != NB_L) bar_nxt = bar_cur + 4'd1;
    end
  end

  // Advance the column counters on every pixel strobe.
  always_ff @(posedge clock) begin
    if (enable) begin
      phase_q <= phase_nxt;
      bar_q   <= bar_nxt;
    end
  end

  // Remember that the counters have been aligned to a line start.
  always_ff @(posedge clock) begin
    if (reset)                     line_ok_q <= 1'b0;
    else if (enable && line_start) line_ok_q <= 1'b1;
  end

  // Frame detection, frame counter, rotation offset and blink phase.
  always_ff @(posedge clock) begin
    if (reset) begin
      seen_q   <= 1'b0;
      mode_q   <= 2'b00;
      fcnt_q   <= '0;
      blink_q  <= 1'b0;
      offset_q <= 3'd0;
      tick_p1  <= 1'b0;
    end else begin
      tick_p1 <= frame_start;
      if (enable) begin
        seen_q <= at_origin;
        mode_q <= mode;
        if (mode_chg) begin
          fcnt_q  <= '0;
          blink_q <= 1'b0;
        end else if (frame_start) begin
          if (fcnt_q == FCNT_LAST) begin
            fcnt_q <= '0;
            if (mode == MODE_ROTATE)
              offset_q <= (offset_q == OFF_LAST) ? 3'd0 : offset_q + 3'd1;
            else if (mode == MODE_BLINK)
              blink_q <= ~blink_q;
          end else begin
            fcnt_q <= fcnt_q + FCW'(1);
          end
        end
      end
    end
  end

  // ---- stage 1: registered colour for the sampled pixel ----
  // Register the colour of the pixel presented on this strobe.
  always_ff @(posedge clock) begin
    if (reset)       rgb_p1 <= 24'h000000;
    else if (enable) rgb_p1 <= lit ? palette(wrap_bar(bar_cur, offset_q)) : 24'h000000;
  end

  assign VGA_red       = rgb_p1[23:16];
  assign VGA_green     = rgb_p1[15:8];
  assign VGA_blue      = rgb_p1[7:0];
  assign frame_tick    = tick_p1;
  assign colour_offset = offset_q;

endmodule

// File: tb/tb_colour_bar_pattern_gen.sv
// Bench for colour_bar_pattern_gen: a driver scans pixel coordinates like the
// VGA controller (shortened frames), a reference model predicts every
// registered output into a queue, and a monitor compares at each negedge.
module tb_colour_bar_pattern_gen;

  localparam int NB   = 7;
  localparam int BW   = 75;
  localparam int GAPW = 15;
  localparam int XS   = 0;
  localparam int YS   = 220;
  localparam int YH   = 40;
  localparam int FPS  = 2;
  localparam int P    = GAPW + BW;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [9:0] pixel_X_pos = '0;
  logic [9:0] pixel_Y_pos = '0;
  logic [7:0] VGA_red, VGA_green, VGA_blue;
  logic       frame_tick;
  logic [2:0] colour_offset;

  colour_bar_pattern_gen #(
    .NUM_BARS(NB), .BAR_WIDTH(BW), .GAP(GAPW), .X_START(XS),
    .Y_START(YS), .Y_HEIGHT(YH), .FRAMES_PER_STEP(FPS)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .mode(mode),
    .pixel_X_pos(pixel_X_pos), .pixel_Y_pos(pixel_Y_pos),
    .VGA_red(VGA_red), .VGA_green(VGA_green), .VGA_blue(VGA_blue),
    .frame_tick(frame_tick), .colour_offset(colour_offset)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [23:0] rgb;
    logic        tick;
    logic [2:0]  off;
  } exp_t;

  exp_t sb[$];
  exp_t cur = '0;
  bit   mon_on = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  // Reference model state
  int         m_off, m_cnt;
  bit         m_phase, m_seen, m_first;
  logic [1:0] m_mode;
  logic [1:0] mode_v = 2'b00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [23:0] ref_pal(input int c);
    case (c)
      0: return 24'hFF0000;
      1: return 24'hFFFF00;
      2: return 24'hFFFFFF;
      3: return 24'h00FFFF;
      4: return 24'h00FF00;
      5: return 24'h0000FF;
      6: return 24'hFF00FF;
      default: return 24'h808080;
    endcase
  endfunction

  // Colour straight from the geometric definition using div/mod.
  function automatic logic [23:0] ref_colour(input int x, input int y, input int off, input bit dark);
    int dx, k;
    if (dark || x < XS || y < YS || y >= YS + YH) return 24'h0;
    dx = x - XS;
    k  = dx / P;
    if (k >= NB || (dx % P) < GAPW) return 24'h0;
    return ref_pal((k + off) % NB);
  endfunction

  function automatic bit tbl230(input int x, output logic [23:0] v);
    v = 24'h0;
    case (x)
      14:  v = 24'h000000;
      15:  v = 24'hFF0000;
      89:  v = 24'hFF0000;
      90:  v = 24'h000000;
      105: v = 24'hFFFF00;
      555: v = 24'hFF00FF;
      630: v = 24'h000000;
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_off = 0; m_cnt = 0; m_phase = 0; m_seen = 0; m_first = 1; m_mode = 2'b00;
  endtask

  task automatic model_pix(input int x, input int y, input logic [1:0] md);
    exp_t e;
    bit at0, fs;
    at0    = (x == 0) && (y == 0);
    fs     = at0 && !m_seen;
    e.rgb  = m_first ? 24'h0 : ref_colour(x, y, m_off, m_phase);
    e.tick = fs;
    m_first = 0;
    m_seen  = at0;
    if (md != m_mode) begin
      m_cnt = 0; m_phase = 0;
    end else if (fs) begin
      m_cnt++;
      if (m_cnt == FPS) begin
        m_cnt = 0;
        if (md == 2'b01) m_off = (m_off + 1) % NB;
        else if (md == 2'b10) m_phase = !m_phase;
      end
    end
    m_mode = md;
    e.off  = 3'(m_off);
    sb.push_back(e);
  endtask

  task automatic pix(input int x, input int y, input bit chk, input logic [23:0] ev);
    @(negedge clock);
    pixel_X_pos = 10'(x); pixel_Y_pos = 10'(y); mode = mode_v; enable = 1'b1;
    @(posedge clock);
    model_pix(x, y, mode_v);
    if (chk) begin
      #1 check("directed_pixel", {8'h0, VGA_red, VGA_green, VGA_blue}, {8'h0, ev});
    end
    @(negedge clock);
    enable = 1'b0;
    if ($urandom_range(0, 7) == 0) @(negedge clock);
  endtask

  task automatic do_reset(input int n);
    @(negedge clock);
    reset = 1'b1; mode_v = 2'b00; mode = 2'b00;
    for (int i = 0; i < n; i++) begin
      enable = 1'($urandom_range(0, 1));
      @(posedge clock);
      model_reset();
      sb.push_back('0);
      mon_on = 1;
      @(negedge clock);
    end
    reset = 1'b0; enable = 1'b0;
  endtask

  // One shortened frame: a few pixels of row 0 then one scanned row.
  task automatic frame(input int row, input int ncols, input logic [1:0] md, input int dmode);
    logic [23:0] ev;
    bit chk;
    mode_v = md;
    for (int x = 0; x < 4; x++) pix(x, 0, 1'b0, 24'h0);
    for (int x = 0; x < ncols; x++) begin
      chk = 0; ev = 24'h0;
      case (dmode)
        1: chk = tbl230(x, ev);
        2: chk = 1;
        3: if (x == 15 && m_off <= 1) begin chk = 1; ev = (m_off == 1) ? 24'hFFFF00 : 24'hFF0000; end
        4: if (x == 200) begin chk = 1; ev = m_phase ? 24'h000000 : 24'hFFFFFF; end
        default: chk = 0;
      endcase
      pix(x, row, chk, ev);
    end
  endtask

  // Monitor: each active edge yields one queued expectation; otherwise hold.
  always @(negedge clock) begin
    if (mon_on) begin
      if (sb.size() > 0) begin
        cur = sb.pop_front();
        check("output", {4'h0, VGA_red, VGA_green, VGA_blue, frame_tick, colour_offset}, {4'h0, cur});
      end else begin
        check("hold", {4'h0, VGA_red, VGA_green, VGA_blue, frame_tick, colour_offset},
              {4'h0, cur.rgb, 1'b0, cur.off});
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running at %0t, required to have finished", $time);
    $fatal(1);
  end

  initial begin
    int rows[8];
    int off_before;
    logic [1:0] md;
    rows = '{219, 220, 230, 239, 240, 259, 260, 0};
    model_reset();

    do_reset(3);

    // Static pattern with literal spot checks
    frame(230, 640, 2'b00, 1);
    frame(219, 640, 2'b00, 2);
    frame(260, 640, 2'b00, 2);
    frame(240, 640, 2'b00, 0);
    frame($urandom_range(221, 258), 640, 2'b00, 0);

    // Rotate across more than one full wrap of the offset
    for (int f = 0; f < 30; f++) frame(230, (f % 4 == 0) ? 640 : 120, 2'b01, 3);

    // Blink
    for (int f = 0; f < 8; f++) frame(240, 300, 2'b10, 4);

    // Mode change coinciding with a step: change wins
    frame(230, 120, 2'b01, 0);
    frame(230, 120, 2'b01, 0);
    off_before = m_off;
    frame(230, 120, 2'b00, 0);
    check("switch_keeps_offset", {29'h0, colour_offset}, 32'(off_before));
    frame(230, 120, 2'b01, 0);
    frame(230, 120, 2'b01, 0);
    frame(230, 120, 2'b01, 0);
    frame(230, 120, 2'b11, 0);
    frame(230, 120, 2'b11, 0);

    // Randomised modes, rows and line lengths
    md = 2'b01;
    for (int f = 0; f < 20; f++) begin
      if ($urandom_range(0, 9) < 3) md = 2'($urandom_range(0, 3));
      rows[7] = $urandom_range(1, 479);
      frame(rows[$urandom_range(0, 7)], $urandom_range(20, 640), md, 0);
    end

    // Reset in the middle of a lit line
    mode_v = 2'b01;
    for (int x = 0; x <= 300; x++) pix(x, 230, 1'b0, 24'h0);
    do_reset(1);
    pix(301, 230, 1'b1, 24'h000000);
    frame(230, 640, 2'b00, 1);
    frame(230, 120, 2'b01, 0);

    repeat (4) @(negedge clock);
    check("queue_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
